// File: rtl/ef_wb_regs_pkg.sv
// Register page layout shared by the EF peripheral wrappers: offsets within
// the 0xFF page, the page tag and the value returned for unmapped offsets.
package ef_wb_regs_pkg;

    localparam logic [7:0] FF_PAGE  = 8'hFF;

    localparam logic [7:0] IM_OFS   = 8'h00;
    localparam logic [7:0] MIS_OFS  = 8'h04;
    localparam logic [7:0] RIS_OFS  = 8'h08;
    localparam logic [7:0] IC_OFS   = 8'h0C;
    localparam logic [7:0] GCLK_OFS = 8'h10;

    localparam logic [31:0] DEADBEEF_VAL = 32'hDEADBEEF;

    // Expands the four byte selects into a 32-bit per-bit write mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/ef_wb_irq_gclk_ctrl_if.sv
// Wishbone slave-side bundle for the 0xFF control page, including the
// page-hit flag the wrapper uses to steer strobes to the peripheral core.
interface ef_wb_irq_gclk_ctrl_if;

    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic [3:0]  sel_i;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        page_hit_o;

    modport master (
        output adr_i, dat_i, sel_i, cyc_i, stb_i, we_i,
        input  dat_o, ack_o, page_hit_o
    );

    modport slave (
        input  adr_i, dat_i, sel_i, cyc_i, stb_i, we_i,
        output dat_o, ack_o, page_hit_o
    );

endinterface

// File: rtl/ef_gating_cell.sv
// Glitch-free clock gate: the enable is captured while the clock is low, so
// clk_o can only start or stop on a full high phase of clk_i.
module ef_gating_cell (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic clk_o
);

    logic en_q;

    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en_i;
        end
    end

    assign clk_o = clk_i & en_q;

endmodule

// File: rtl/ef_sync_n.sv
// Per-bit N-stage synchroniser for asynchronous interrupt sources.
module ef_sync_n #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d[0] = d_i;
        for (int k = 1; k < STAGES; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/ef_wb_irq_gclk_ctrl.sv
// Wishbone control page for EF wrappers: IM/MIS/RIS/IC/GCLK registers,
// per-source level or sticky-edge interrupt capture, registered IRQ and clock gate.
module ef_wb_irq_gclk_ctrl
    import ef_wb_regs_pkg::*;
#(
    parameter int                 NUM_IRQ     = 9,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '0,
    parameter int                 SYNC_STAGES = 0,
    parameter logic               GCLK_RESET  = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    ef_wb_irq_gclk_ctrl_if.slave   wb,
    input  logic [NUM_IRQ-1:0]     flags_i,
    input  logic                   sc_testmode,
    output logic                   clk_g,
    output logic                   IRQ
);

    logic               hit;
    logic               wb_valid;
    logic               wr_commit;
    logic [7:0]         ofs;
    logic [31:0]        lane_m;
    logic [NUM_IRQ-1:0] wmask;
    logic [NUM_IRQ-1:0] src;

    logic               ack_q,      ack_d;
    logic               irq_q,      irq_d;
    logic               gclk_q,     gclk_d;
    logic [NUM_IRQ-1:0] im_q,       im_d;
    logic [NUM_IRQ-1:0] ris_edge_q, ris_edge_d;
    logic [NUM_IRQ-1:0] src_dly_q,  src_dly_d;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] ris;
    logic [NUM_IRQ-1:0] mis;
    logic [31:0]        rd_data;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            ef_sync_n #(
                .WIDTH  (NUM_IRQ),
                .STAGES (SYNC_STAGES)
            ) u_sync (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .d_i   (flags_i),
                .q_o   (src)
            );
        end else begin : g_nosync
            assign src = flags_i;
        end
    endgenerate

    assign hit       = (wb.adr_i[15:8] == FF_PAGE);
    assign ofs       = wb.adr_i[7:0];
    assign wb_valid  = wb.cyc_i & wb.stb_i;
    assign wr_commit = wb_valid & hit & wb.we_i & ~ack_q;
    assign lane_m    = lane_mask(wb.sel_i);
    assign wmask     = lane_m[NUM_IRQ-1:0];

    // Level sources are live; edge sources come from the sticky capture flops.
    assign rise = src & ~src_dly_q & EDGE_MASK;
    assign ris  = (src & ~EDGE_MASK) | (ris_edge_q & EDGE_MASK);
    assign mis  = ris & im_q;

    always_comb begin
        ack_d      = wb_valid & hit & ~ack_q;
        irq_d      = |mis;
        src_dly_d  = src;
        im_d       = im_q;
        gclk_d     = gclk_q;
        clr        = '0;

        if (wr_commit) begin
            case (ofs)
                IM_OFS:   im_d = (im_q & ~wmask) | (wb.dat_i[NUM_IRQ-1:0] & wmask);
                IC_OFS:   clr  = wb.dat_i[NUM_IRQ-1:0] & wmask;
                GCLK_OFS: if (wb.sel_i[0]) gclk_d = wb.dat_i[0];
                default:  ;
            endcase
        end

        // A capture and a clear in the same cycle keep the flag set.
        ris_edge_d = ((ris_edge_q & ~clr) | rise) & EDGE_MASK;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q      <= 1'b0;
            irq_q      <= 1'b0;
            gclk_q     <= GCLK_RESET;
            im_q       <= '0;
            ris_edge_q <= '0;
            src_dly_q  <= '0;
        end else begin
            ack_q      <= ack_d;
            irq_q      <= irq_d;
            gclk_q     <= gclk_d;
            im_q       <= im_d;
            ris_edge_q <= ris_edge_d;
            src_dly_q  <= src_dly_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (ofs)
            IM_OFS:   rd_data[NUM_IRQ-1:0] = im_q;
            MIS_OFS:  rd_data[NUM_IRQ-1:0] = mis;
            RIS_OFS:  rd_data[NUM_IRQ-1:0] = ris;
            IC_OFS:   rd_data = '0;
            GCLK_OFS: rd_data[0] = gclk_q;
            default:  rd_data = DEADBEEF_VAL;
        endcase
    end

    assign wb.dat_o      = hit ? rd_data : '0;
    assign wb.ack_o      = ack_q;
    assign wb.page_hit_o = hit;
    assign IRQ           = irq_q;

    ef_gating_cell u_gate (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (sc_testmode | gclk_q),
        .clk_o (clk_g)
    );

    logic unused_bits;
    assign unused_bits = ^{wb.adr_i[31:16], wb.dat_i, lane_m};

endmodule

// File: doc/ef_wb_irq_gclk_ctrl.md
# ef_wb_irq_gclk_ctrl

Parametrised Wishbone-side control block for EF peripheral wrappers: owns the 0xFF00–0xFF10 register page (IM, MIS, RIS, IC, GCLK), the per-source interrupt capture logic, the registered IRQ output and the DFT-aware clock gate. It replaces the hard-wired 9-bit level-only interrupt logic of the current wrappers with N sources. Each source is configurable as level or edge (sticky, write-1-to-clear) and can be optionally synchronised. The peripheral core sits beside it and serves all addresses outside the 0xFF page.

## Interface
Parameters:
- NUM_IRQ, 9: number of interrupt sources, 1..32.
- EDGE_MASK, 0: per-source mode bit; 1 means rising-edge sticky, 0 means level.
- SYNC_STAGES, 0: synchroniser flops on flags_i; 0 means none, otherwise 2..3.
- GCLK_RESET, 1'b0: reset value of GCLK_REG.

Ports:
- clk_i  in  1  bus clock, ungated. Clock clk_i.
- rst_i  in  1  reset. Reset rst_i, asynchronous, active-high.
- adr_i  in  32  Wishbone address; only [15:0] decoded.
- dat_i  in  32  write data.
- sel_i  in  4  byte selects.
- cyc_i, stb_i, we_i  in  1  Wishbone control.
- dat_o  out  32  read data for 0xFF-page hits.
- ack_o  out  1  acknowledge for 0xFF-page hits only.
- page_hit_o  out  1  adr_i[15:8]==8'hFF; the wrapper uses it to steer stb to the core.
- flags_i  in  NUM_IRQ  raw interrupt sources from the core.
- sc_testmode  in  1  scan test mode; forces the clock enable.
- clk_g  out  1  gated core clock.
- IRQ  out  1  registered interrupt request.

## Operation
Decode:
- hit = page_hit_o; wb_valid = cyc_i & stb_i.
- Register offsets: IM 0xFF00 (RW), MIS 0xFF04 (RO), RIS 0xFF08 (RO), IC 0xFF0C (WO, reads 0), GCLK 0xFF10 (RW, bit 0).
- Any other offset in the 0xFF page reads 32'hDEADBEEF.
- Writes to RO or unmapped offsets are acked and ignored.

Writes:
- A write commits on the edge where wb_valid & hit & we_i & ~ack_o.
- Byte lanes are honoured via sel_i for IM and IC. GCLK uses sel_i[0].

Source path:
- flags_i passes through SYNC_STAGES flops (reset 0) to give s[i].
- Level source: RIS[i] = s[i] (live). IC has no effect.
- Edge source: s_d[i] is s[i] delayed one cycle. RIS[i] sets when s[i] & ~s_d[i]. RIS[i] clears on an IC write with a 1 in bit i. If set and clear occur in the same cycle, set wins.

Outputs:
- MIS = RIS & IM.
- IRQ is a flop, loaded every cycle with |MIS.
- Clock gate: clk_gated_en = sc_testmode | GCLK_REG[0], fed to ef_gating_cell driving clk_g.
- Read data is zero-extended above NUM_IRQ.

## Timing
Reset values:
- IM=0, RIS sticky bits=0, sync/delay flops=0, GCLK_REG=GCLK_RESET, ack_o=0, IRQ=0.

Ack:
- ack_o <= wb_valid & hit & ~ack_o.
- It rises one cycle after the request and is high for exactly one cycle.
- A held request is therefore acked every other cycle.
- When hit=0, ack_o stays 0.

Read data:
- dat_o is combinational from adr_i and the current register state. It is valid while ack_o is high.

Latencies:
- flags_i edge to RIS set: SYNC_STAGES+1 cycles (edge source), SYNC_STAGES cycles (level source).
- RIS to IRQ: 1 cycle.
- IC write: takes effect on the commit edge; IRQ drops 1 cycle later.
- GCLK write: enable changes on the commit edge; the gating cell latches it glitch-free.

Reset mid-operation:
- An in-progress transaction is dropped with no ack. All sticky state is lost.

## Structure
- Shared package ef_wb_regs_pkg holds the offset localparams (IM, MIS, RIS, IC, GCLK), FF_PAGE = 8'hFF and DEADBEEF_VAL. Existing wrappers migrate to it.
- Sub-module: the existing ef_gating_cell, one instance.
- Optional sub-module: ef_sync_n, a per-bit N-stage synchroniser generated when SYNC_STAGES>0.

## Test plan
- Reset: read all five offsets. Expect IM=0, RIS=0, MIS=0, IC=0, GCLK=GCLK_RESET, IRQ=0, and 0xFF14 reads 32'hDEADBEEF.
- Level source (NUM_IRQ=9, EDGE_MASK=0, SYNC_STAGES=0): IM=0x001, hold flags_i[0]=1. Expect RIS=0x001, MIS=0x001, IRQ=1 one cycle later. Deassert the flag: RIS=0 and IRQ=0 next cycle.
- Edge source (EDGE_MASK=9'h100): 1-cycle pulse on flags_i[8]. Expect RIS=0x100 to stay set. Write IC=0x100: RIS=0, IRQ falls one cycle after the commit.
- Set/clear collision: a rising edge on flags_i[8] coincides with the IC=0x100 commit edge. Expect RIS[8] to remain 1.
- Handshake: stb held 4 cycles at 0xFF00. Expect ack pattern 0,1,0,1. Address 0x0004 with stb: ack_o stays 0 and page_hit_o=0.
- Clock gate: GCLK=0 with sc_testmode=0: clk_g stays low. Set sc_testmode=1: clk_g toggles. Write GCLK=1 with sc_testmode=0: clk_g toggles.
